// File: rtl/case_conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : case_conv_pkg
//  Description : Shared types, ASCII bounds and letter classifiers for the
//                streaming case converter.
//  Revision    : 1.0  initial release
// ============================================================================
package case_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_UPPER = 2'd1,
        MODE_LOWER = 2'd2,
        MODE_TITLE = 2'd3
    } mode_e;

    localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
    localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
    localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;
    localparam logic [7:0] CASE_DELTA     = 8'h20;

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= ASCII_UPPER_LO) && (b <= ASCII_UPPER_HI);
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_LOWER_LO) && (b <= ASCII_LOWER_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/case_conv_lane.sv
`default_nettype none
// ============================================================================
//  Module      : case_conv_lane
//  Description : Combinational single-byte case converter. Title-case word
//                state enters on word_start_i and leaves on word_start_o so
//                lanes can be chained within a beat.
//  Revision    : 1.0  initial release
// ============================================================================
module case_conv_lane
    import case_conv_pkg::*;
(
    input  logic [7:0] byte_i,
    input  logic [1:0] mode_i,
    input  logic       word_start_i,
    output logic [7:0] byte_o,
    output logic       word_start_o,
    output logic       changed_o
);

    logic w_upper;
    logic w_lower;

    // Convert one byte; only ASCII letters are ever modified
    always_comb begin
        w_upper = is_upper(byte_i);
        w_lower = is_lower(byte_i);
        byte_o  = byte_i;
        case (mode_i)
            MODE_UPPER: if (w_lower) byte_o = byte_i - CASE_DELTA;
            MODE_LOWER: if (w_upper) byte_o = byte_i + CASE_DELTA;
            MODE_TITLE: begin
                if (word_start_i && w_lower)
                    byte_o = byte_i - CASE_DELTA;
                else if (!word_start_i && w_upper)
                    byte_o = byte_i + CASE_DELTA;
            end
            default: ;
        endcase
        // Any non-letter ends the current word
        word_start_o = !(w_upper || w_lower);
        changed_o    = (byte_o != byte_i);
    end

endmodule
`default_nettype wire

// File: rtl/case_convert_stream.sv
`default_nettype none
// ============================================================================
//  Module      : case_convert_stream
//  Description : LANES-byte valid/ready stream case converter with frame
//                delimiting. Modes pass/upper/lower/title; mode is latched on
//                the first beat of each frame. One registered output stage.
//                Optional converted-byte counter enabled by the macro
//                CASE_CONV_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module case_convert_stream
    import case_conv_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode_i,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_last
`ifdef CASE_CONV_STATS_EN
    ,
    output logic [CNT_W-1:0]   conv_count
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic               word_start_q, word_start_d;
    logic               out_valid_q, out_valid_d;
    logic [8*LANES-1:0] out_data_q, out_data_d;
    logic               out_last_q, out_last_d;

    logic               w_accept;
    logic               w_first;
    logic [1:0]         w_beat_mode;
    logic               w_ws_seed;
    logic               w_ws_final;
    logic [8*LANES-1:0] w_conv_data;
    logic [LANES-1:0]   w_changed;

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Frame tracking: a beat with in_last closes the frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept && !in_last) state_d = ST_FRAME;
            ST_FRAME: if (w_accept &&  in_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake and per-beat context derived from the frame state
    always_comb begin
        in_ready    = !out_valid_q || out_ready;
        w_accept    = in_valid && in_ready;
        w_first     = (state_q == ST_IDLE);
        // First beat uses the live mode; later beats use the latched one
        w_beat_mode = w_first ? mode_i : mode_q;
        w_ws_seed   = w_first ? 1'b1 : word_start_q;
    end

    // Lane chain: word state ripples from lane 0 upward
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic w_ws_in;
        logic w_ws_out;
        if (i == 0) begin : g_head
            assign w_ws_in = w_ws_seed;
        end else begin : g_link
            assign w_ws_in = g_lane[i-1].w_ws_out;
        end
        case_conv_lane u_lane (
            .byte_i       (in_data[8*i +: 8]),
            .mode_i       (w_beat_mode),
            .word_start_i (w_ws_in),
            .byte_o       (w_conv_data[8*i +: 8]),
            .word_start_o (w_ws_out),
            .changed_o    (w_changed[i])
        );
    end
    assign w_ws_final = g_lane[LANES-1].w_ws_out;

    // Next values for the output stage and frame context
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        word_start_d = word_start_q;
        mode_d       = mode_q;
        if (w_accept) begin
            out_valid_d  = 1'b1;
            out_data_d   = w_conv_data;
            out_last_d   = in_last;
            word_start_d = w_ws_final;
            if (w_first) mode_d = mode_i;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage and frame context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            word_start_q <= 1'b1;
            mode_q       <= MODE_PASS;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            word_start_q <= word_start_d;
            mode_q       <= mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

`ifdef CASE_CONV_STATS_EN
    logic [CNT_W-1:0] conv_count_q, conv_count_d;
    logic [CNT_W:0]   w_count_sum;

    // Saturating sum of altered lanes on every output-register load
    always_comb begin
        w_count_sum = {1'b0, conv_count_q};
        for (int i = 0; i < LANES; i++) begin
            w_count_sum = w_count_sum + {{CNT_W{1'b0}}, w_changed[i]};
        end
        conv_count_d = conv_count_q;
        if (w_accept) begin
            conv_count_d = w_count_sum[CNT_W] ? {CNT_W{1'b1}} : w_count_sum[CNT_W-1:0];
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) conv_count_q <= '0;
        else     conv_count_q <= conv_count_d;
    end

    assign conv_count = conv_count_q;
`else
    // Change flags and counter width have no consumer without statistics
    logic w_unused_stats;
    assign w_unused_stats = ^{w_changed, CNT_W[0]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_case_convert_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_case_convert_stream
//  Description : Self-checking bench for case_convert_stream: directed frames
//                followed by a random stream against a frame-level model.
//                Counter checks follow CASE_CONV_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_case_convert_stream;

    localparam int LANES = 4;
    localparam int CNT_W = 16;
    localparam int W     = 8 * LANES;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic [1:0]   mode_i    = 2'd0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data   = '0;
    logic         in_last   = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
`ifdef CASE_CONV_STATS_EN
    logic [CNT_W-1:0] conv_count;
`endif

    always #5 clk = ~clk;

    case_convert_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_i    (mode_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef CASE_CONV_STATS_EN
        ,
        .conv_count(conv_count)
`endif
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t      exp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    bit         in_frame = 1'b0;
    logic [1:0] frame_mode = 2'd0;
    bit         ws = 1'b1;
    longint     exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: the text of a frame is converted as one running
    // character sequence; mode and word state restart with every frame.
    task automatic model_accept(input logic [W-1:0] d, input logic l, input logic [1:0] m);
        beat_t      bt;
        logic [7:0] b, o;
        bit         up, lo;
        int         changed = 0;
        if (!in_frame) begin
            frame_mode = m;
            ws         = 1'b1;
        end
        for (int i = 0; i < LANES; i++) begin
            b  = d[8*i +: 8];
            up = (b >= 8'h41) && (b <= 8'h5A);
            lo = (b >= 8'h61) && (b <= 8'h7A);
            o  = b;
            case (frame_mode)
                2'd1: if (lo) o = b - 8'h20;
                2'd2: if (up) o = b + 8'h20;
                2'd3: if (ws && lo) o = b - 8'h20; else if (!ws && up) o = b + 8'h20;
                default: ;
            endcase
            ws = !(up || lo);
            if (o != b) changed++;
            bt.data[8*i +: 8] = o;
        end
        bt.last = l;
        exp_q.push_back(bt);
        exp_cnt = exp_cnt + changed;
        if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
        in_frame = !l;
    endtask

    // One clock cycle: drive, check handshake and any drained beat, advance.
    task automatic step(input logic v, input logic [W-1:0] d, input logic l,
                        input logic [1:0] m, input logic r, output bit acc);
        beat_t bt;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        mode_i    = m;
        out_ready = r;
        #1;
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("in_ready", in_ready, (exp_q.size() == 0) || r);
        acc = v && in_ready;
        if (exp_q.size() != 0 && r) begin
            bt = exp_q.pop_front();
            chk("out_data", out_data, bt.data);
            chk("out_last", out_last, bt.last);
        end
        if (acc) model_accept(d, l, m);
        @(posedge clk);
        #1;
`ifdef CASE_CONV_STATS_EN
        chk("conv_count", conv_count, exp_cnt);
`endif
    endtask

    task automatic send(input logic [W-1:0] d, input logic l, input logic [1:0] m);
        bit acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) step(1'b1, d, l, m, 1'b1, acc);
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        in_frame = 1'b0;
        exp_cnt  = 0;
    endtask

    function automatic logic [7:0] rand_byte();
        int p = $urandom_range(0, 9);
        if (p < 4)  return 8'(8'h41 + $urandom_range(0, 25));
        if (p < 8)  return 8'(8'h61 + $urandom_range(0, 25));
        if (p == 8) return ($urandom_range(0, 1) != 0) ? 8'h20 : 8'h2D;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        bit           acc;
        longint       saved_cnt;
        logic [W-1:0] d;

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef CASE_CONV_STATS_EN
        chk("rst_conv_count", conv_count, 0);
`endif

        // UPPER single beat "hElL" -> "HELL"
        send(32'h4C6C4568, 1'b1, 2'd1);
        chk("upper_hell", out_data, 32'h4C4C4548);
        chk("upper_hell_last", out_last, 1'b1);
`ifdef CASE_CONV_STATS_EN
        chk("upper_hell_cnt", conv_count, 2);
`endif

        // TITLE across a beat boundary: "aB c" "dE-f" -> "Ab C" "de-F"
        send(32'h63204261, 1'b0, 2'd3);
        chk("title_b0", out_data, 32'h43206241);
        send(32'h662D4564, 1'b1, 2'd3);
        chk("title_b1", out_data, 32'h462D6564);
        send(32'h61616161, 1'b1, 2'd3);
        chk("title_newframe", out_data, 32'h61616141);

        // Backpressure: held beat stays stable, nothing accepted
        send(32'h64636261, 1'b1, 2'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 32'h7A7A7A7A, 1'b1, 2'd2, 1'b0, acc);
            chk("stall_acc", acc, 1'b0);
            chk("stall_data", out_data, 32'h44434241);
        end
        step(1'b1, 32'h7A7A7A7A, 1'b1, 2'd2, 1'b1, acc);
        chk("release_acc", acc, 1'b1);
        chk("release_data", out_data, 32'h7A7A7A7A);

        // Mode change mid-frame is ignored
        send(32'h64636261, 1'b0, 2'd1);
        chk("mode_b0", out_data, 32'h44434241);
        send(32'h64636261, 1'b0, 2'd2);
        chk("mode_b1", out_data, 32'h44434241);
        send(32'h64636261, 1'b1, 2'd2);
        chk("mode_b2", out_data, 32'h44434241);
        send(32'h44434241, 1'b1, 2'd2);
        chk("mode_next", out_data, 32'h64636261);

        // Non-letters, including high bytes, never change
        saved_cnt = exp_cnt;
        send(32'h407BC1E1, 1'b1, 2'd1);
        chk("nonletter", out_data, 32'h407BC1E1);
`ifdef CASE_CONV_STATS_EN
        chk("nonletter_cnt", conv_count, saved_cnt);
`endif

        // Reset in the middle of a frame
        send(32'h61616161, 1'b0, 2'd3);
        do_reset();
        chk("midrst_valid", out_valid, 1'b0);
`ifdef CASE_CONV_STATS_EN
        chk("midrst_cnt", conv_count, 0);
`endif
        send(32'h2E2E7978, 1'b1, 2'd3);
        chk("midrst_title", out_data, 32'h2E2E7958);

        // Random stream with random valid/ready
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < LANES; i++) d[8*i +: 8] = rand_byte();
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, acc);
        end
        for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, 2'd0, 1'b1, acc);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
